// File: rtl/flag_pkg.sv
// Shared types for the flag/branch control slice: NZCV layout, ARM condition
// codes, squash FSM states and the squash counter width.
package flag_pkg;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef enum logic {
    IDLE   = 1'b0,
    SQUASH = 1'b1
  } state_e;

  localparam int SQ_CNT_W = $clog2(8);

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator; shared between branch resolution
// and conditional-select logic.
module cond_eval
  import flag_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true = flags.z;
      COND_NE: cond_true = !flags.z;
      COND_HS: cond_true = flags.c;
      COND_LO: cond_true = !flags.c;
      COND_MI: cond_true = flags.n;
      COND_PL: cond_true = !flags.n;
      COND_VS: cond_true = flags.v;
      COND_VC: cond_true = !flags.v;
      COND_HI: cond_true = flags.c && !flags.z;
      COND_LS: cond_true = !flags.c || flags.z;
      COND_GE: cond_true = (flags.n == flags.v);
      COND_LT: cond_true = (flags.n != flags.v);
      COND_GT: cond_true = !flags.z && (flags.n == flags.v);
      COND_LE: cond_true = flags.z || (flags.n != flags.v);
      COND_AL: cond_true = 1'b1;
      COND_NV: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_branch_ctrl.sv
// Architectural NZCV flag owner and ID-stage branch resolver with a
// programmable wrong-path squash window and saturating taken-branch counter.
module flag_branch_ctrl
  import flag_pkg::*;
#(
  parameter int SQUASH_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             ex_set_flags,
  input  logic [3:0]       ex_flags,
  input  logic             id_valid,
  input  logic             id_is_bcond,
  input  logic [3:0]       id_cond,
  input  logic             id_is_cbz,
  input  logic             id_is_cbnz,
  input  logic             id_reg_zero,
  input  logic             id_uncond,
  output logic [3:0]       flags_o,
  output logic             branch_taken,
  output logic             flush_if,
  output logic             busy,
  output logic [CNT_W-1:0] taken_count
);

  nzcv_t                flags_q, flags_d, eff_flags;
  logic                 ex_writes_flags, cond_true, branch_ok;
  state_e               state_q;
  logic [SQ_CNT_W-1:0]  sq_cnt_q;
  logic                 flush_if_q, busy_q;
  logic [CNT_W-1:0]     taken_count_q, taken_count_d;

  assign ex_writes_flags = ex_valid && ex_set_flags;
  // EX results bypass the flag register so a B.cond right behind ADDS/SUBS sees them
  assign eff_flags = ex_writes_flags ? nzcv_t'(ex_flags) : flags_q;

  cond_eval u_cond_eval (
    .flags    (eff_flags),
    .cond     (cond_e'(id_cond)),
    .cond_true(cond_true)
  );

  always_comb begin
    branch_ok    = id_uncond
                || (id_is_bcond && cond_true)
                || (id_is_cbz && id_reg_zero)
                || (id_is_cbnz && !id_reg_zero);
    branch_taken = id_valid && !stall && (state_q == IDLE) && branch_ok;
  end

  always_comb begin
    flags_d = flags_q;
    if (ex_writes_flags && !stall) flags_d = nzcv_t'(ex_flags);
    taken_count_d = taken_count_q;
    if (branch_taken && !(&taken_count_q)) taken_count_d = taken_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q       <= '0;
      taken_count_q <= '0;
    end else begin
      flags_q       <= flags_d;
      taken_count_q <= taken_count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      sq_cnt_q   <= '0;
      flush_if_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        IDLE: begin
          if (branch_taken) begin
            state_q    <= SQUASH;
            sq_cnt_q   <= SQ_CNT_W'(SQUASH_CYCLES - 1);
            flush_if_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        SQUASH: begin
          if (sq_cnt_q == '0) begin
            state_q    <= IDLE;
            flush_if_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            sq_cnt_q <= sq_cnt_q - SQ_CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // At most one branch-type strobe may accompany a valid ID instruction
  assert property (@(posedge clk) disable iff (!reset)
    id_valid |-> $onehot0({id_is_bcond, id_is_cbz, id_is_cbnz, id_uncond}));

  assign flags_o     = flags_q;
  assign flush_if    = flush_if_q;
  assign busy        = busy_q;
  assign taken_count = taken_count_q;

endmodule

// File: doc/flag_branch_ctrl.md
Name: flag_branch_ctrl

Overview:
- Owns the architectural NZCV flags and resolves conditional branches in ID.
- Commits flags from flag-setting instructions in EX. Forwards EX flags to a B.cond sitting in ID in the same cycle.
- Evaluates B.cond, CBZ, CBNZ and B/BL in ID, then squashes wrong-path fetches for a programmable number of cycles.
- Keeps a saturating count of taken branches for the perf counters.

Parameters:
SQUASH_CYCLES, 1, bubbles inserted after a taken branch (1..7).
CNT_W, 16, width of taken_count.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
stall  in  1  pipeline stall; freezes flag commit, FSM, counter and branch evaluation
ex_valid  in  1  EX holds a valid instruction
ex_set_flags  in  1  EX instruction sets flags (ADDS/SUBS/ANDS)
ex_flags  in  4  ALU result flags {N,Z,C,V}
id_valid  in  1  ID holds a valid instruction
id_is_bcond  in  1  ID instruction is B.cond
id_cond  in  4  B.cond condition field
id_is_cbz  in  1  ID instruction is CBZ
id_is_cbnz  in  1  ID instruction is CBNZ
id_reg_zero  in  1  forwarded CB operand equals zero
id_uncond  in  1  ID instruction is B or BL
flags_o  out  4  committed NZCV {N,Z,C,V}
branch_taken  out  1  combinational redirect request for the PC mux
flush_if  out  1  registered; kill instruction entering ID
busy  out  1  FSM not IDLE
taken_count  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (reset=0, async):
  - flags_o=4'b0000, FSM=IDLE, squash counter=0.
  - flush_if=0, busy=0, taken_count=0.
- Flag commit:
  - Condition: ex_valid & ex_set_flags & ~stall at the rising edge → flags_o <= ex_flags.
  - Latency: 1 cycle.
  - Otherwise flags_o holds.
- Forwarding:
  - eff_flags = ex_flags when ex_valid & ex_set_flags, else flags_o.
  - Forwarding is not gated by stall.
- Condition evaluation (on eff_flags):
  - EQ Z, NE !Z, HS C, LO !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL and NV (1110, 1111) are always true.
- Branch resolution:
  - Valid branch: id_valid & ~stall & FSM==IDLE.
  - branch_taken = valid branch & (id_uncond | id_is_bcond&cond_true | id_is_cbz&id_reg_zero | id_is_cbnz&~id_reg_zero).
  - Multiple type strobes asserted at once is illegal; assert in simulation.
- FSM, states IDLE and SQUASH:
  - IDLE→SQUASH on branch_taken; squash counter loads SQUASH_CYCLES-1.
  - In SQUASH: flush_if=1, busy=1, branch evaluation suppressed.
  - In SQUASH: counter decrements each non-stalled cycle; at 0 and not stalled → IDLE.
  - Stall in SQUASH: state and counter hold, flush_if stays 1.
- taken_count:
  - Increments on each cycle with branch_taken=1.
  - Saturates at all-ones and does not wrap.
- Simultaneous events:
  - Flag-setting instruction in EX plus B.cond in ID → branch uses ex_flags, and the flags also commit that edge.
  - Taken branch with stall=1 → no redirect; evaluation retried after the stall.
- Reset asserted mid-SQUASH → immediately IDLE, flush_if=0, with no residual squash cycles.

Decomposition:
- Package flag_pkg:
  - typedef nzcv_t (packed struct n,z,c,v).
  - enum cond_e with the 16 condition codes.
  - enum state_e {IDLE, SQUASH}.
  - Localparam for SQUASH counter width ($clog2(8)).
- Sub-module cond_eval (combinational): inputs nzcv_t flags and cond_e cond, output cond_true. Reused later by conditional-select logic.

Test Plan:
- Reset sequence: flags_o=0, taken_count=0, flush_if=0. Then SUBS in EX with ex_flags=4'b0100, stall=0 → flags_o=4'b0100 one edge later.
- Forwarding: flags_o=0, EX SUBS ex_flags=4'b0100, same cycle B.EQ (id_cond=0000) → branch_taken=1. Same setup with B.NE → branch_taken=0.
- Squash length: SQUASH_CYCLES=3, B taken → flush_if=1 for exactly 3 cycles. Second B in ID during those cycles → no branch_taken, taken_count increments by 1 only.
- Stall: B.GE with N=1,V=1 held under stall=1 for 2 cycles → branch_taken=0 throughout. Stall drops → branch_taken=1 once. Stall during SQUASH extends flush_if by the stall length.
- CBZ/CBNZ and signed conditions:
  - CBZ with id_reg_zero=1 → taken; CBNZ with id_reg_zero=1 → not taken.
  - LE with Z=0,N=1,V=0 → taken; HI with C=1,Z=1 → not taken.
- Saturation and async reset: CNT_W=4, 17 taken branches → taken_count=15. reset=0 mid-SQUASH, between clock edges → busy=0, flush_if=0, taken_count=0 immediately.
